// File: rtl/voice_allocator.sv
// Touch-key to synth-voice allocator: one key served per clock,
// release-voice reuse, idle-first fill and oldest-voice stealing.
module voice_allocator #(
    parameter int NUM_KEYS       = 12,
    parameter int NUM_VOICES     = 4,
    parameter int RELEASE_CYCLES = 1024
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_KEYS-1:0]     touch_status_in,
    output logic [NUM_VOICES-1:0]   voice_gate_out,
    output logic [NUM_VOICES-1:0]   voice_trigger_out,
    output logic [NUM_VOICES-1:0]   voice_release_out,
    output logic [NUM_VOICES*4-1:0] voice_note_out,
    output logic                    steal_out
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int TW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        V_IDLE   = 2'd0,
        V_ACTIVE = 2'd1,
        V_REL    = 2'd2
    } vstate_t;

    logic [NUM_KEYS-1:0]   touch_q, pending, pending_n;
    logic [NUM_KEYS-1:0]   press, rel;
    logic [15:0]           rel_ext;
    vstate_t               state   [NUM_VOICES];
    vstate_t               state_n [NUM_VOICES];
    logic [3:0]            note    [NUM_VOICES];
    logic [3:0]            note_n  [NUM_VOICES];
    logic [TW-1:0]         timer   [NUM_VOICES];
    logic [TW-1:0]         timer_n [NUM_VOICES];
    logic [VW-1:0]         rank    [NUM_VOICES];
    logic [VW-1:0]         rank_n  [NUM_VOICES];
    logic [NUM_VOICES-1:0] trigger, trigger_n;
    logic                  steal, steal_n;

    logic          serve;
    logic [KW-1:0] serve_key;
    logic [3:0]    serve_note;
    logic          same_hit, idle_hit, rel_hit, steal_sel;
    logic [VW-1:0] same_idx, idle_idx, rel_idx, act_idx, target;
    logic [VW-1:0] rel_rank, act_rank;

    assign press      = touch_status_in & ~touch_q;
    assign rel        = ~touch_status_in & touch_q;
    assign rel_ext    = 16'(rel);
    assign serve_note = 4'(serve_key);

    // Lowest-indexed pending key that is still held wins this cycle.
    always_comb begin
        serve     = 1'b0;
        serve_key = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k] && touch_status_in[k]) begin
                serve     = 1'b1;
                serve_key = KW'(k);
            end
        end
    end

    always_comb begin
        same_hit = 1'b0;
        same_idx = '0;
        idle_hit = 1'b0;
        idle_idx = '0;
        rel_hit  = 1'b0;
        rel_idx  = '0;
        rel_rank = '0;
        act_idx  = '0;
        act_rank = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (state[v] == V_REL && note[v] == serve_note) begin
                same_hit = 1'b1;
                same_idx = VW'(v);
            end
            if (state[v] == V_IDLE) begin
                idle_hit = 1'b1;
                idle_idx = VW'(v);
            end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state[v] == V_REL && (!rel_hit || rank[v] > rel_rank)) begin
                rel_hit  = 1'b1;
                rel_idx  = VW'(v);
                rel_rank = rank[v];
            end
            if (state[v] == V_ACTIVE && rank[v] >= act_rank) begin
                act_idx  = VW'(v);
                act_rank = rank[v];
            end
        end
        steal_sel = 1'b0;
        if (same_hit) begin
            target = same_idx;
        end else if (idle_hit) begin
            target = idle_idx;
        end else if (rel_hit) begin
            target = rel_idx;
        end else begin
            target    = act_idx;
            steal_sel = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            touch_q <= '0;
            pending <= '0;
            trigger <= '0;
            steal   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state[v] <= V_IDLE;
                note[v]  <= '0;
                timer[v] <= '0;
                rank[v]  <= VW'(v);
            end
        end else begin
            touch_q <= touch_status_in;
            pending <= pending_n;
            trigger <= trigger_n;
            steal   <= steal_n;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state[v] <= state_n[v];
                note[v]  <= note_n[v];
                timer[v] <= timer_n[v];
                rank[v]  <= rank_n[v];
            end
        end
    end

    // An assignment overrides any release or timeout on the same voice.
    always_comb begin
        pending_n = (pending | press) & touch_status_in;
        if (serve) pending_n[serve_key] = 1'b0;
        trigger_n = '0;
        steal_n   = serve & steal_sel;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_n[v] = state[v];
            note_n[v]  = note[v];
            timer_n[v] = timer[v];
            rank_n[v]  = rank[v];
            case (state[v])
                V_REL: begin
                    if (timer[v] == '0) state_n[v] = V_IDLE;
                    else timer_n[v] = timer[v] - 1'b1;
                end
                V_ACTIVE: begin
                    if (rel_ext[note[v]]) begin
                        state_n[v] = V_REL;
                        timer_n[v] = T_LOAD;
                    end
                end
                default: ;
            endcase
            if (serve && target == VW'(v)) begin
                state_n[v]   = V_ACTIVE;
                note_n[v]    = serve_note;
                timer_n[v]   = '0;
                rank_n[v]    = '0;
                trigger_n[v] = 1'b1;
            end else if (serve && rank[v] < rank[target]) begin
                rank_n[v] = rank[v] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_gate_out[v]       = (state[v] == V_ACTIVE);
            voice_release_out[v]    = (state[v] == V_REL);
            voice_note_out[4*v +: 4] = note[v];
        end
        voice_trigger_out = trigger;
        steal_out         = steal;
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: vector table through a
// scoreboard queue, plus an asynchronous mid-release reset sequence.
module tb_voice_allocator;

    localparam int NK = 12;
    localparam int NV = 4;
    localparam int RC = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [NK-1:0] touch_status_in;
    logic [NV-1:0] voice_gate_out;
    logic [NV-1:0] voice_trigger_out;
    logic [NV-1:0] voice_release_out;
    logic [NV*4-1:0] voice_note_out;
    logic          steal_out;

    int checks = 0;
    int errors = 0;

    voice_allocator #(
        .NUM_KEYS(NK),
        .NUM_VOICES(NV),
        .RELEASE_CYCLES(RC)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .touch_status_in(touch_status_in),
        .voice_gate_out(voice_gate_out),
        .voice_trigger_out(voice_trigger_out),
        .voice_release_out(voice_release_out),
        .voice_note_out(voice_note_out),
        .steal_out(steal_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          rst;
        logic [11:0] touch;
        logic [3:0]  gate;
        logic [3:0]  trig;
        logic [3:0]  rel;
        logic [15:0] note;
        logic        steal;
        bit          rk;
        logic [7:0]  rank;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic void add(bit r, logic [11:0] t, logic [3:0] g,
                                logic [3:0] tr, logic [3:0] rl,
                                logic [15:0] n, logic s,
                                bit rk = 0, logic [7:0] rnk = 8'h00);
        vec_t v;
        v.rst = r; v.touch = t; v.gate = g; v.trig = tr; v.rel = rl;
        v.note = n; v.steal = s; v.rk = rk; v.rank = rnk;
        tbl.push_back(v);
    endfunction

    function automatic logic [7:0] ranks();
        return {dut.rank[3], dut.rank[2], dut.rank[1], dut.rank[0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_out(string name, vec_t e);
        checks++;
        if ({voice_gate_out, voice_trigger_out, voice_release_out,
             voice_note_out, steal_out} !==
            {e.gate, e.trig, e.rel, e.note, e.steal}) begin
            errors++;
            $display("FAIL %s: got gate=%b trig=%b rel=%b note=%h steal=%b, expected gate=%b trig=%b rel=%b note=%h steal=%b",
                     name, voice_gate_out, voice_trigger_out,
                     voice_release_out, voice_note_out, steal_out,
                     e.gate, e.trig, e.rel, e.note, e.steal);
        end
        if (e.rk) chk({name, " rank"}, 32'(ranks()), 32'(e.rank));
    endtask

    initial begin
        rst_in = 1'b1;
        touch_status_in = '0;
        #1;
        chk("reset_outputs",
            {3'b0, voice_gate_out, voice_trigger_out, voice_release_out,
             voice_note_out, steal_out}, 32'h0);
        chk("reset_rank", 32'(ranks()), 32'hE4);

        // single press of key 5
        add(1, 12'h000, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 1, 8'hE4);
        add(0, 12'h020, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h020, 4'h1, 4'h1, 4'h0, 16'h0005, 0);
        add(0, 12'h020, 4'h1, 4'h0, 4'h0, 16'h0005, 0);
        add(0, 12'h000, 4'h0, 4'h0, 4'h1, 16'h0005, 0);
        // keys 1,3,7 together, served one per clock
        add(1, 12'h08A, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h08A, 4'h1, 4'h1, 4'h0, 16'h0001, 0);
        add(0, 12'h08A, 4'h3, 4'h2, 4'h0, 16'h0031, 0);
        add(0, 12'h08A, 4'h7, 4'h4, 4'h0, 16'h0731, 0);
        add(0, 12'h08A, 4'h7, 4'h0, 4'h0, 16'h0731, 0);
        // drop key 3: exactly RC cycles of release, note held
        for (int i = 0; i < RC; i++)
            add(0, 12'h082, 4'h5, 4'h0, 4'h2, 16'h0731, 0);
        add(0, 12'h082, 4'h5, 4'h0, 4'h0, 16'h0731, 0);
        // two releases in one cycle
        add(0, 12'h000, 4'h0, 4'h0, 4'h5, 16'h0731, 0);
        // fill all voices, then steal the oldest
        add(1, 12'h00F, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 1, 8'hE4);
        add(0, 12'h00F, 4'h1, 4'h1, 4'h0, 16'h0000, 0);
        add(0, 12'h00F, 4'h3, 4'h2, 4'h0, 16'h0010, 0);
        add(0, 12'h00F, 4'h7, 4'h4, 4'h0, 16'h0210, 0);
        add(0, 12'h00F, 4'hF, 4'h8, 4'h0, 16'h3210, 0, 1, 8'h1B);
        add(0, 12'h01F, 4'hF, 4'h0, 4'h0, 16'h3210, 0);
        add(0, 12'h01F, 4'hF, 4'h1, 4'h0, 16'h3214, 1, 1, 8'h6C);
        add(0, 12'h01F, 4'hF, 4'h0, 4'h0, 16'h3214, 0);
        // same-note release voice preferred over idle voices
        add(1, 12'h004, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h004, 4'h1, 4'h1, 4'h0, 16'h0002, 0);
        add(0, 12'h000, 4'h0, 4'h0, 4'h1, 16'h0002, 0);
        add(0, 12'h004, 4'h0, 4'h0, 4'h1, 16'h0002, 0);
        add(0, 12'h004, 4'h1, 4'h1, 4'h0, 16'h0002, 0);
        // tap released before service is dropped
        add(1, 12'h000, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h040, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h000, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h000, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        // key held through reset deassertion counts as a press
        add(1, 12'h200, 4'h0, 4'h0, 4'h0, 16'h0000, 0);
        add(0, 12'h200, 4'h1, 4'h1, 4'h0, 16'h0009, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                @(negedge clk_in);
                touch_status_in = tbl[i].touch;
                rst_in = 1'b1;
                @(negedge clk_in);
                rst_in = 1'b0;
            end else begin
                @(negedge clk_in);
            end
            touch_status_in = tbl[i].touch;
            exp_q.push_back(tbl[i]);
            @(posedge clk_in);
            #1;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL row %0d: scoreboard empty", i);
            end else begin
                chk_out($sformatf("row%0d", i), exp_q.pop_front());
            end
        end

        // asynchronous reset in the middle of a release
        @(negedge clk_in);
        rst_in = 1'b1;
        touch_status_in = 12'h300;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        touch_status_in = 12'h000;
        @(posedge clk_in);
        #1;
        chk("mid_release_state",
            {3'b0, voice_gate_out, voice_trigger_out, voice_release_out,
             voice_note_out, steal_out},
            {3'b0, 4'h0, 4'h0, 4'h3, 16'h0098, 1'b0});
        chk("mid_release_rank", 32'(ranks()), 32'hE1);
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        chk("async_reset_outputs",
            {3'b0, voice_gate_out, voice_trigger_out, voice_release_out,
             voice_note_out, steal_out}, 32'h0);
        chk("async_reset_rank", 32'(ranks()), 32'hE4);
        @(negedge clk_in);
        rst_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_KEYS, 12, number of touch keys; legal range 2..16.
REQ-002 Parameter NUM_VOICES, 4, number of synth voices; legal range 2..8.
REQ-003 Parameter RELEASE_CYCLES, 1024, release-phase length in clocks; must be >= 1.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 touch_status_in  input  NUM_KEYS  level per key, 1 = touched, already synchronous to clk_in.
REQ-007 voice_gate_out  output  NUM_VOICES  1 = voice in ACTIVE state.
REQ-008 voice_trigger_out  output  NUM_VOICES  one-cycle pulse when a voice is (re)assigned a note.
REQ-009 voice_release_out  output  NUM_VOICES  1 = voice in RELEASE state.
REQ-010 voice_note_out  output  NUM_VOICES*4  key index per voice; voice v occupies bits [4v+3:4v].
REQ-011 steal_out  output  1  one-cycle pulse when an ACTIVE voice is stolen.

Function
REQ-012 A registered copy touch_q of touch_status_in SHALL give press = touch_status_in & ~touch_q and rel = ~touch_status_in & touch_q.
REQ-013 Register pending SHALL set a bit on press and clear it when served or when that key is no longer touched.
REQ-014 Per clock at most one pending key SHALL be served: the lowest-indexed pending bit whose key is still touched.
REQ-015 Single-press latency: key rising before edge k, served at edge k+1; gate, note and trigger SHALL be valid after edge k+1.
REQ-016 Each voice SHALL hold state IDLE, ACTIVE or RELEASE, a 4-bit note, a release timer and a rank (0 = most recently assigned, NUM_VOICES-1 = oldest).
REQ-017 Target selection priority: (1) RELEASE voice holding the same note; (2) lowest-index IDLE voice; (3) oldest-rank RELEASE voice; (4) oldest-rank ACTIVE voice.
REQ-018 Selection SHALL use voice states registered at the start of the cycle.
REQ-019 Assignment SHALL set target ACTIVE, load note, clear timer, pulse its trigger bit, and give it rank 0.
REQ-020 Assignment SHALL increment every other voice whose rank was below the target's old rank; all ranks remain a permutation of 0..NUM_VOICES-1.
REQ-021 Choice (4) SHALL pulse steal_out in the same cycle as the trigger.
REQ-022 On rel of key n, every ACTIVE voice with note n that is not being assigned this cycle SHALL go RELEASE with timer = RELEASE_CYCLES-1.
REQ-023 A voice assigned and matching rel in the same cycle SHALL take the assignment; the release is ignored.
REQ-024 A RELEASE voice SHALL decrement its timer each clock and go IDLE on the clock its timer reads 0.
REQ-025 voice_note_out SHALL hold the last note through RELEASE and IDLE.
REQ-026 Releases on multiple keys in one cycle SHALL all be applied in that cycle.
REQ-027 A key pressed and released before being served SHALL be dropped: no trigger, no state change.

Reset
REQ-028 While rst_in is high, all state SHALL clear immediately, independent of clk_in: touch_q, pending, timers and all outputs to 0, every voice IDLE, note 0, rank[v] = v.
REQ-029 Keys held when rst_in deasserts SHALL be detected as presses on the first clock after deassertion.

Verification (bench uses RELEASE_CYCLES = 16)
REQ-030 Reset; raise key 5 alone -> after edge k+1, voice 0 gate=1, note=5, trigger pulse exactly 1 cycle; steal_out=0.
REQ-031 Raise keys 1, 3, 7 in the same cycle -> voices 0, 1, 2 get notes 1, 3, 7 on three consecutive edges; one trigger per cycle.
REQ-032 Drop key 3 -> voice 1 gate=0, release_out=1 for exactly 16 cycles, then IDLE with note still 3.
REQ-033 Hold keys 0, 1, 2, 3, then press key 4 -> voice 0 (oldest) gets note 4, trigger and steal_out pulse together, voice 0 rank 0.
REQ-034 Release key 2 and re-press within 16 cycles while a voice is IDLE -> the same voice retriggers with note 2 (priority 1).
REQ-035 Assert rst_in asynchronously mid-release -> all outputs 0 before the next clock edge; ranks return to 0..3.
